// File: rtl/bf16_pkg.sv
// Shared BFloat16 types, constants and operand classification helpers
// for the multiply-accumulate datapath.
package bf16_pkg;

  typedef struct packed {
    logic       s;
    logic [7:0] e;
    logic [6:0] m;
  } bf16_t;

  localparam int unsigned BF16_BIAS    = 127;
  localparam logic [7:0]  BF16_EXP_MAX = 8'hFF;
  localparam logic [7:0]  BF16_INF_EXP = 8'hFF;
  localparam bf16_t       BF16_QNAN    = bf16_t'({1'b0, 8'hFF, 7'h40});

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  // Subnormals are flushed, so any zero exponent counts as zero.
  function automatic logic is_zero(input bf16_t x);
    return x.e == 8'h00;
  endfunction

  function automatic logic is_inf(input bf16_t x);
    return (x.e == BF16_EXP_MAX) && (x.m == 7'h00);
  endfunction

  function automatic logic is_nan(input bf16_t x);
    return (x.e == BF16_EXP_MAX) && (x.m != 7'h00);
  endfunction

endpackage

// File: rtl/bf16_mul_seq_if.sv
// Operand/result handshake bundle between a producer and bf16_mul_seq.
interface bf16_mul_seq_if;

  logic       in_valid_i;
  logic       in_ready_o;
  logic       sa_i;
  logic [7:0] ea_i;
  logic [6:0] ma_i;
  logic       sb_i;
  logic [7:0] eb_i;
  logic [6:0] mb_i;
  logic       out_valid_o;
  logic       out_ready_i;
  logic       s_o;
  logic [7:0] e_o;
  logic [6:0] m_o;

  modport master (
    output in_valid_i, sa_i, ea_i, ma_i, sb_i, eb_i, mb_i, out_ready_i,
    input  in_ready_o, out_valid_o, s_o, e_o, m_o
  );

  modport slave (
    input  in_valid_i, sa_i, ea_i, ma_i, sb_i, eb_i, mb_i, out_ready_i,
    output in_ready_o, out_valid_o, s_o, e_o, m_o
  );

endinterface

// File: rtl/bf16_round_norm.sv
// Normalise a [1,4) significand product, round to nearest even and clamp
// overflow to Inf / underflow to zero. Shared with bf16_add.
module bf16_round_norm
  import bf16_pkg::*;
(
  input  logic              sign,
  input  logic signed [9:0] exp,
  input  logic [15:0]       prod,
  output bf16_t             res
);

  logic [6:0]        mant;
  logic              guard;
  logic              sticky;
  logic              rnd;
  logic [7:0]        mant_r;
  logic signed [9:0] e_adj;

  always_comb begin
    mant   = '0;
    guard  = 1'b0;
    sticky = 1'b0;
    e_adj  = exp;
    res    = '0;

    if (prod[15]) begin
      mant   = prod[14:8];
      guard  = prod[7];
      sticky = |prod[6:0];
      e_adj  = exp + 10'sd1;
    end else begin
      mant   = prod[13:7];
      guard  = prod[6];
      sticky = |prod[5:0];
    end

    rnd    = guard & (sticky | mant[0]);
    mant_r = {1'b0, mant} + 8'(rnd);
    // Carry out of the mantissa leaves mant_r[6:0] at zero.
    if (mant_r[7]) e_adj = e_adj + 10'sd1;

    res.s = sign;
    if (e_adj >= 10'sd255) begin
      res.e = BF16_INF_EXP;
      res.m = 7'h00;
    end else if (e_adj <= 10'sd0) begin
      res.e = 8'h00;
      res.m = 7'h00;
    end else begin
      res.e = e_adj[7:0];
      res.m = mant_r[6:0];
    end
  end

endmodule

// File: rtl/bf16_mul_seq.sv
// Iterative shift-add BFloat16 multiplier with constant latency of
// NSTEP+1 cycles from accept to result valid.
module bf16_mul_seq
  import bf16_pkg::*;
#(
  parameter int unsigned STEP_BITS = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  bf16_mul_seq_if.slave bus
);

  localparam int unsigned NSTEP = 8 / STEP_BITS;
  localparam int unsigned CNT_W = 4;

  state_t             state_q, state_d;
  bf16_t              opa_q, opa_d;
  bf16_t              opb_q, opb_d;
  logic [15:0]        a_sh_q, a_sh_d;
  logic [7:0]         b_sh_q, b_sh_d;
  logic [15:0]        acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  bf16_t              res_q, res_d;
  logic [15:0]        partial;
  logic signed [9:0]  e_sum;
  logic               sign;
  bf16_t              rn_res;

  assign sign  = opa_q.s ^ opb_q.s;
  assign e_sum = $signed({2'b00, opa_q.e}) + $signed({2'b00, opb_q.e})
               - $signed(10'(BF16_BIAS));

  bf16_round_norm u_round_norm (
    .sign (sign),
    .exp  (e_sum),
    .prod (acc_q),
    .res  (rn_res)
  );

  // STEP_BITS partial products of A, selected by the low multiplier bits.
  always_comb begin
    partial = '0;
    for (int j = 0; j < STEP_BITS; j++) begin
      if (b_sh_q[3'(j)]) partial = partial + (a_sh_q << j);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid_i) begin
          opa_d   = bf16_t'({bus.sa_i, bus.ea_i, bus.ma_i});
          opb_d   = bf16_t'({bus.sb_i, bus.eb_i, bus.mb_i});
          a_sh_d  = 16'({1'b1, bus.ma_i});
          b_sh_d  = {1'b1, bus.mb_i};
          acc_d   = '0;
          cnt_d   = CNT_W'(NSTEP - 1);
          state_d = MUL;
        end
      end
      MUL: begin
        acc_d  = acc_q + partial;
        a_sh_d = a_sh_q << STEP_BITS;
        b_sh_d = b_sh_q >> STEP_BITS;
        if (cnt_q == '0) state_d = NORM;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      NORM: begin
        // Special operands override the arithmetic path; timing is unchanged.
        if (is_nan(opa_q) || is_nan(opb_q) ||
            (is_inf(opa_q) && is_zero(opb_q)) ||
            (is_zero(opa_q) && is_inf(opb_q))) begin
          res_d = BF16_QNAN;
        end else if (is_inf(opa_q) || is_inf(opb_q)) begin
          res_d = bf16_t'({sign, BF16_INF_EXP, 7'h00});
        end else if (is_zero(opa_q) || is_zero(opb_q)) begin
          res_d = bf16_t'({sign, 8'h00, 7'h00});
        end else begin
          res_d = rn_res;
        end
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready_o  = (state_q == IDLE);
  assign bus.out_valid_o = (state_q == DONE);
  assign bus.s_o         = res_q.s;
  assign bus.e_o         = res_q.e;
  assign bus.m_o         = res_q.m;

endmodule
